gost: RTL and testbench

GOST -- requirements
Module: gost

---
 rtl/gost.sv | 109 ++++++++++
 tb/tb_gost.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/gost.sv
// Magma (GOST R 34.12-2015) 64-bit block cipher, one Feistel round per clock.
// Start/done level handshake; the key is read live and must be held by the requester.
module gost (
    input  logic         iclk,
    input  logic         irst,
    input  logic         istart,
    input  logic         ienc_dec,
    input  logic [255:0] ikey,
    input  logic [63:0]  iblock,
    output logic [63:0]  oblock,
    output logic         odone
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Each row holds pi_i with the entry for input 0 in the top nibble.
    localparam logic [63:0] PI [8] = '{
        64'hC462A5B9E8D703F1,
        64'h68239A5C1E47BD0F,
        64'hB3582FADE174C960,
        64'hC821D4F670A53E9B,
        64'h7F5A816D093EB42C,
        64'h5DF692CAB78143E0,
        64'h8E25691CF4B0DA37,
        64'h17ED05834FA69CB2
    };

    function automatic logic [31:0] g(input logic [31:0] x);
        logic [31:0] s;
        logic [63:0] row;
        logic [5:0]  sel;
        s = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            row = PI[i];
            sel = {~x[4*i +: 4], 2'b00};
            s[4*i +: 4] = row[sel +: 4];
        end
        return {s[20:0], s[31:21]};
    endfunction

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic        mode;
    logic [31:0] a1, a0;
    logic        fwd;
    logic [2:0]  kidx;
    logic [31:0] rk;
    logic [31:0] t;

    // Forward key order for 24 rounds on encrypt, 8 on decrypt; reversed afterwards.
    always_comb begin
        fwd  = mode ? (cnt[4:3] == 2'b00) : (cnt[4:3] != 2'b11);
        kidx = fwd ? cnt[2:0] : ~cnt[2:0];
        rk   = ikey[{~kidx, 5'b00000} +: 32];
        t    = g(a0 + rk) ^ a1;
    end

    always_ff @(posedge iclk) begin
        if (!irst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (istart)       state_nxt = RUN;
            RUN:     if (cnt == 5'd31) state_nxt = DONE;
            DONE:    if (!istart)      state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!irst) begin
            cnt    <= '0;
            mode   <= 1'b0;
            a1     <= '0;
            a0     <= '0;
            oblock <= '0;
            odone  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (istart) begin
                        a1   <= iblock[63:32];
                        a0   <= iblock[31:0];
                        mode <= ienc_dec;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a1  <= a0;
                    a0  <= t;
                    cnt <= cnt + 5'd1;
                    // Final round is unswapped: t goes to the upper half.
                    if (cnt == 5'd31) begin
                        oblock <= {t, a0};
                        odone  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!istart) odone <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gost.sv
// Directed bench for gost: RFC 7801 vectors, handshake, reset abort, idle and round-trip.
module tb_gost;

    localparam logic [255:0] KEY = 256'hFFEEDDCCBBAA99887766554433221100F0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    localparam logic [63:0]  PT  = 64'hFEDCBA9876543210;
    localparam logic [63:0]  CT  = 64'h4EE901E5C2D8CA3D;

    logic         iclk;
    logic         irst;
    logic         istart;
    logic         ienc_dec;
    logic [255:0] ikey;
    logic [63:0]  iblock;
    logic [63:0]  oblock;
    logic         odone;

    int errors = 0;
    int checks = 0;

    gost dut (
        .iclk    (iclk),
        .irst    (irst),
        .istart  (istart),
        .ienc_dec(ienc_dec),
        .ikey    (ikey),
        .iblock  (iblock),
        .oblock  (oblock),
        .odone   (odone)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts an operation from IDLE and waits for odone; istart left high on return.
    task automatic run_op(input string tag, input logic dec, input logic [63:0] blk,
                          input bit wiggle, input logic [63:0] hold, output logic [63:0] res);
        int n;
        ienc_dec = dec;
        iblock   = blk;
        istart   = 1'b1;
        tick();
        iblock   = ~blk;
        ienc_dec = ~dec;
        check({tag, "_odone_low_after_start"}, {63'd0, odone}, 64'd0);
        n = 0;
        while (!odone && n < 40) begin
            tick();
            n++;
            if (wiggle && n == 5) istart = 1'b0;
            if (wiggle && n == 8) istart = 1'b1;
            if (n == 10) check({tag, "_oblock_hold_in_run"}, oblock, hold);
        end
        check({tag, "_latency"}, 64'(n), 64'd32);
        res = oblock;
    endtask

    task automatic release_start(input string tag, input logic [63:0] exp);
        istart = 1'b0;
        tick();
        check({tag, "_odone_drop"}, {63'd0, odone}, 64'd0);
        check({tag, "_oblock_after_drop"}, oblock, exp);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] rblk;
        logic [63:0] rct;
        int bad;

        irst = 1'b0; istart = 1'b0; ienc_dec = 1'b0; ikey = KEY; iblock = '0;
        repeat (3) tick();
        check("reset_odone", {63'd0, odone}, 64'd0);
        check("reset_oblock", oblock, 64'd0);
        irst = 1'b1;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (odone !== 1'b0 || oblock !== 64'd0) bad++;
        end
        check("idle_100_quiet", 64'(bad), 64'd0);

        run_op("enc1", 1'b0, PT, 1'b0, 64'd0, res);
        check("enc1_oblock", res, CT);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hs_odone_held", {63'd0, odone}, 64'd1);
            check("hs_oblock_stable", oblock, CT);
        end
        release_start("hs", CT);

        run_op("dec1", 1'b1, CT, 1'b1, CT, res);
        check("dec1_oblock", res, PT);
        release_start("dec1", PT);

        ienc_dec = 1'b0; iblock = PT; istart = 1'b1;
        repeat (11) tick();
        irst = 1'b0;
        tick();
        check("abort_odone", {63'd0, odone}, 64'd0);
        check("abort_oblock", oblock, 64'd0);
        tick();
        check("abort_rst_prio_odone", {63'd0, odone}, 64'd0);
        irst = 1'b1; istart = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (odone !== 1'b0) bad++;
        end
        check("abort_no_odone", 64'(bad), 64'd0);

        run_op("enc2", 1'b0, PT, 1'b0, 64'd0, res);
        check("enc2_oblock", res, CT);
        release_start("enc2", CT);

        rblk = {$urandom, $urandom};
        run_op("rnd_enc", 1'b0, rblk, 1'b0, CT, rct);
        release_start("rnd_enc", rct);
        run_op("rnd_dec", 1'b1, rct, 1'b0, rct, res);
        check("rnd_roundtrip", res, rblk);
        release_start("rnd_dec", rblk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
